io_to_axi: RTL and testbench
============================

# io_to_axi

Reverse bridge from the IO bus to the on-chip a/b bus: accepts single-word strobed transfers from an external IO-bus master (the USB/host side or a debug master) and replays each one as exactly one a/b-bus request. It waits for the single-cycle response and returns it to the IO master with a registered `io_ready` pulse. It sits beside `cpu0` as a second a/b initiator, upstream of the address decoder and any arbiter.

## Interface
- `TIMEOUT_CYCLES`, 1024: cycles from entering REQ to abort; only used with `IO_TO_AXI_TIMEOUT_EN`; legal range 2..65535.
- `ERR_DATA`, 32'hFFFFFFFF: `io_read_data` value returned on timeout.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `io_addr_strobe` in 1: transfer start, one-cycle pulse.
- `io_read_strobe` in 1: read qualifier, valid with `io_addr_strobe`.
- `io_write_strobe` in 1: write qualifier, valid with `io_addr_strobe`.
- `io_addr` in 32: byte address; bits [1:0] ignored.
- `io_byte_enable` in 4: write byte lanes.
- `io_write_data` in 32: write data.
- `io_read_data` out 32: response data, valid only while `io_ready`=1.
- `io_ready` out 1: one-cycle completion pulse.
- `avalid` out 1: a/b request valid.
- `aready` in 1: a/b request accepted when `avalid && aready`.
- `awe` out 1: 1 = write.
- `aaddr` out 30 [31:2]: word address.
- `adata` out 32: write data.
- `astrb` out 4: byte strobes; 4'hF on reads.
- `bvalid` in 1: one-cycle response.
- `bdata` in 32: response data.
- `busy` out 1: transaction outstanding (state != IDLE).
- `overrun` out 1: sticky; a strobe arrived while busy.
- `timeout` out 1: sticky; a transaction was aborted.

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: on `io_addr_strobe` with `io_read_strobe` or `io_write_strobe`, latch `io_addr[31:2]`, `io_write_data`, `io_byte_enable`, and `awe` = `io_write_strobe`. Go to REQ.
  - Both qualifiers set: treated as a write.
  - `io_addr_strobe` with neither qualifier: ignored.
- REQ: `avalid`=1, all a-side outputs held stable. On `aready`=1, go to WAIT.
- WAIT: `avalid`=0. On `bvalid`=1, go to IDLE and, in the next cycle, pulse `io_ready`.
  - Reads: `io_read_data` = `bdata` captured in the `bvalid` cycle.
  - Writes: `io_read_data` = 0.
- `bvalid` seen in IDLE or REQ is ignored. Responders assert `bvalid` no earlier than the cycle after acceptance.
- Strobe while busy: the transfer is dropped, `overrun` is set to 1, and the current transaction is unaffected. `overrun` and `timeout` are cleared only by reset.
- Strobe in the same cycle as the `io_ready` pulse: accepted. State is already IDLE, so back-to-back transfers are legal.
- `io_read_data` is 0 whenever `io_ready`=0.
- Reset, including mid-transaction: state = IDLE and all outputs 0. The latched request is discarded with no `io_ready`. An in-flight `bvalid` after reset is ignored.

## Timing
- Strobe in cycle N: `avalid` is 1 from N+1.
- Zero-wait responder (`aready`=1 at N+1, `bvalid` at N+2): `io_ready` at N+3. Minimum latency is 3 cycles.
- Each extra `aready`-low cycle or `bvalid` delay cycle adds one cycle of latency.
- `io_ready` and `io_read_data` are registered outputs. `avalid`, `busy` and the a-side buses are also registered.

## Configuration
- `IO_TO_AXI_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entering REQ and counts every cycle in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES-1` without `bvalid`: go to IDLE, drop `avalid` even if not accepted, set `timeout`, and pulse `io_ready` next cycle with `io_read_data` = `ERR_DATA` (writes too).
  - If `bvalid` occurs in the same cycle as the timeout, `bvalid` wins: normal completion, `timeout` not set.
  - A late `bvalid` arriving in IDLE is ignored.
- Not defined: no counter, the transaction waits forever, and `timeout` is tied to 0. Port list is identical in both builds.

## Test plan
- Read 0xC2000004, `aready`=1 and `bvalid` next cycle with `bdata`=0x12345678 -> `aaddr`=0x30800001, `awe`=0, `astrb`=4'hF; `io_ready` at N+3 with 0x12345678.
- Write 0xC1000010, data 0xA5A5A5A5, BE 4'b0110, `aready` low 3 cycles -> `avalid` held 4 cycles with stable `astrb`=4'b0110; `io_ready` 1 cycle after `bvalid`; `io_read_data`=0.
- Strobe during WAIT with a different address -> a-side is unchanged, `overrun`=1, exactly one `io_ready`.
- Back-to-back: new strobe in the `io_ready` cycle -> second `avalid` the next cycle, two `io_ready` pulses total.
- `rst_n` low in WAIT, then `bvalid` after release -> no `io_ready`, all outputs 0, `busy`=0.
- With `IO_TO_AXI_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, `aready` held 0 -> `avalid` drops after 8 cycles, `timeout`=1, `io_ready` with 0xFFFFFFFF. Repeat with `bvalid` on the 8th cycle -> normal data, `timeout`=0.

Source files
------------

// File: rtl/io_to_axi.sv
// io_to_axi: replays single-word IO-bus transfers as one a/b-bus request each
// and returns the single-cycle b response to the IO master as an io_ready pulse.
// Optional feature macro: IO_TO_AXI_TIMEOUT_EN aborts a transaction that sees
// no response within TIMEOUT_CYCLES cycles and answers it with ERR_DATA.
module io_to_axi #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_addr_strobe,
  input  logic        io_read_strobe,
  input  logic        io_write_strobe,
  input  logic [31:0] io_addr,
  input  logic [3:0]  io_byte_enable,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        io_ready,
  output logic        avalid,
  input  logic        aready,
  output logic        awe,
  output logic [29:0] aaddr,
  output logic [31:0] adata,
  output logic [3:0]  astrb,
  input  logic        bvalid,
  input  logic [31:0] bdata,
  output logic        busy,
  output logic        overrun,
  output logic        timeout
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_t;

  state_t state;
  state_t state_next;
  logic   transfer;
  logic   start;
  logic   complete;
  logic   abort;
  logic   expired;

  // The byte offset within a word has no meaning on the word-wide a/b bus.
  logic [1:0] unused_addr;
  assign unused_addr = io_addr[1:0];

  assign transfer = io_addr_strobe & (io_read_strobe | io_write_strobe);

`ifdef IO_TO_AXI_TIMEOUT_EN
  logic [15:0] timer;

  assign expired = (timer == 16'(TIMEOUT_CYCLES - 1));

  // Age counter for the outstanding transaction, restarted on every new request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (start) begin
      timer <= '0;
    end else if (state != ST_IDLE) begin
      timer <= timer + 16'd1;
    end
  end

  // Sticky record that at least one transaction was aborted for lack of response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else if (abort) begin
      timeout <= 1'b1;
    end
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = TIMEOUT_CYCLES;
  assign expired    = 1'b0;
  assign timeout    = 1'b0;
`endif

  // Next-state decode; a response arriving together with expiry completes normally.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (transfer) begin
          start      = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (expired) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else if (aready) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bvalid) begin
          complete   = 1'b1;
          state_next = ST_IDLE;
        end else if (expired) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register with avalid and busy registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      avalid <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_next;
      avalid <= (state_next == ST_REQ);
      busy   <= (state_next != ST_IDLE);
    end
  end

  // Capture the request once at acceptance so the a-side stays stable until done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awe   <= 1'b0;
      aaddr <= '0;
      adata <= '0;
      astrb <= '0;
    end else if (start) begin
      awe   <= io_write_strobe;
      aaddr <= io_addr[31:2];
      adata <= io_write_data;
      astrb <= io_write_strobe ? io_byte_enable : 4'hF;
    end
  end

  // One-cycle completion pulse; read data is forced to zero outside the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_ready     <= 1'b0;
      io_read_data <= '0;
    end else begin
      io_ready <= complete | abort;
      if (abort) begin
        io_read_data <= ERR_DATA;
      end else if (complete && !awe) begin
        io_read_data <= bdata;
      end else begin
        io_read_data <= '0;
      end
    end
  end

  // Sticky record of a transfer that was dropped because one was still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (transfer && (state != ST_IDLE)) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_to_axi.sv
// tb_io_to_axi: directed checks of io_to_axi with hand-computed expectations.
// Timeout scenarios are exercised when IO_TO_AXI_TIMEOUT_EN is defined.
module tb_io_to_axi;

  logic        clk;
  logic        rst_n;
  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [31:0] io_addr;
  logic [3:0]  io_byte_enable;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        io_ready;
  logic        avalid;
  logic        aready;
  logic        awe;
  logic [29:0] aaddr;
  logic [31:0] adata;
  logic [3:0]  astrb;
  logic        bvalid;
  logic [31:0] bdata;
  logic        busy;
  logic        overrun;
  logic        timeout;

  int total;
  int bad;
  int pulses;

  io_to_axi #(
    .TIMEOUT_CYCLES(8),
    .ERR_DATA      (32'hFFFF_FFFF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .io_addr_strobe (io_addr_strobe),
    .io_read_strobe (io_read_strobe),
    .io_write_strobe(io_write_strobe),
    .io_addr        (io_addr),
    .io_byte_enable (io_byte_enable),
    .io_write_data  (io_write_data),
    .io_read_data   (io_read_data),
    .io_ready       (io_ready),
    .avalid         (avalid),
    .aready         (aready),
    .awe            (awe),
    .aaddr          (aaddr),
    .adata          (adata),
    .astrb          (astrb),
    .bvalid         (bvalid),
    .bdata          (bdata),
    .busy           (busy),
    .overrun        (overrun),
    .timeout        (timeout)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    io_addr_strobe  = 1'b1;
    io_read_strobe  = rd;
    io_write_strobe = wr;
    io_addr         = addr;
    io_write_data   = wdata;
    io_byte_enable  = be;
  endtask

  task automatic clearStrobe();
    io_addr_strobe  = 1'b0;
    io_read_strobe  = 1'b0;
    io_write_strobe = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clearStrobe();
    io_addr        = '0;
    io_write_data  = '0;
    io_byte_enable = '0;
    aready         = 1'b0;
    bvalid         = 1'b0;
    bdata          = '0;

    // reset state
    tick();
    checkOutput("rst_avalid", {31'd0, avalid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ready", {31'd0, io_ready}, 32'd0);
    checkOutput("rst_rdata", io_read_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // strobe without qualifier and stray bvalid in IDLE are both ignored
    io_addr_strobe = 1'b1;
    io_addr        = 32'h0000_0040;
    bvalid         = 1'b1;
    bdata          = 32'h1111_1111;
    tick();
    clearStrobe();
    bvalid = 1'b0;
    checkOutput("noqual_busy", {31'd0, busy}, 32'd0);
    checkOutput("noqual_avalid", {31'd0, avalid}, 32'd0);
    tick();
    checkOutput("idle_bvalid_ready", {31'd0, io_ready}, 32'd0);

    // zero-wait read
    applyStimulus(1'b1, 1'b0, 32'hC200_0004, 32'h0, 4'h0);
    tick();
    clearStrobe();
    checkOutput("rd_avalid", {31'd0, avalid}, 32'd1);
    checkOutput("rd_aaddr", {2'b00, aaddr}, 32'h3080_0001);
    checkOutput("rd_awe", {31'd0, awe}, 32'd0);
    checkOutput("rd_astrb", {28'd0, astrb}, 32'hF);
    checkOutput("rd_busy", {31'd0, busy}, 32'd1);
    aready = 1'b1;
    tick();
    aready = 1'b0;
    checkOutput("rd_wait_avalid", {31'd0, avalid}, 32'd0);
    checkOutput("rd_early_ready", {31'd0, io_ready}, 32'd0);
    bvalid = 1'b1;
    bdata  = 32'h1234_5678;
    tick();
    bvalid = 1'b0;
    checkOutput("rd_ready", {31'd0, io_ready}, 32'd1);
    checkOutput("rd_data", io_read_data, 32'h1234_5678);
    tick();
    checkOutput("rd_ready_off", {31'd0, io_ready}, 32'd0);
    checkOutput("rd_data_off", io_read_data, 32'd0);
    checkOutput("rd_busy_off", {31'd0, busy}, 32'd0);

    // write with aready held low for three cycles
    applyStimulus(1'b0, 1'b1, 32'hC100_0010, 32'hA5A5_A5A5, 4'b0110);
    tick();
    clearStrobe();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wr_avalid%0d", i), {31'd0, avalid}, 32'd1);
      checkOutput($sformatf("wr_astrb%0d", i), {28'd0, astrb}, 32'h6);
      checkOutput($sformatf("wr_aaddr%0d", i), {2'b00, aaddr}, 32'h3040_0004);
      checkOutput($sformatf("wr_adata%0d", i), adata, 32'hA5A5_A5A5);
      checkOutput($sformatf("wr_awe%0d", i), {31'd0, awe}, 32'd1);
      aready = (i == 3);
      tick();
    end
    aready = 1'b0;
    checkOutput("wr_wait_avalid", {31'd0, avalid}, 32'd0);
    bvalid = 1'b1;
    bdata  = 32'hDEAD_BEEF;
    tick();
    bvalid = 1'b0;
    checkOutput("wr_ready", {31'd0, io_ready}, 32'd1);
    checkOutput("wr_data", io_read_data, 32'd0);
    tick();
    checkOutput("wr_ready_off", {31'd0, io_ready}, 32'd0);

    // strobe during WAIT is dropped and flagged
    checkOutput("ovr_pre", {31'd0, overrun}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    tick();
    clearStrobe();
    aready = 1'b1;
    tick();
    aready = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h0000_0200, 32'h7777_7777, 4'hF);
    tick();
    clearStrobe();
    checkOutput("ovr_flag", {31'd0, overrun}, 32'd1);
    checkOutput("ovr_aaddr", {2'b00, aaddr}, 32'h0000_0040);
    checkOutput("ovr_awe", {31'd0, awe}, 32'd0);
    checkOutput("ovr_avalid", {31'd0, avalid}, 32'd0);
    bvalid = 1'b1;
    bdata  = 32'hCAFE_0001;
    tick();
    bvalid = 1'b0;
    checkOutput("ovr_data", io_read_data, 32'hCAFE_0001);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (io_ready) pulses++;
      tick();
    end
    checkOutput("ovr_pulses", pulses, 32'd1);
    checkOutput("ovr_sticky", {31'd0, overrun}, 32'd1);

    // back-to-back: new strobe in the io_ready cycle
    pulses = 0;
    applyStimulus(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
    tick();
    clearStrobe();
    aready = 1'b1;
    tick();
    aready = 1'b0;
    bvalid = 1'b1;
    bdata  = 32'hAAAA_0001;
    tick();
    bvalid = 1'b0;
    if (io_ready) pulses++;
    checkOutput("b2b_data1", io_read_data, 32'hAAAA_0001);
    applyStimulus(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0);
    tick();
    clearStrobe();
    if (io_ready) pulses++;
    checkOutput("b2b_avalid2", {31'd0, avalid}, 32'd1);
    checkOutput("b2b_aaddr2", {2'b00, aaddr}, 32'h0000_0800);
    aready = 1'b1;
    tick();
    aready = 1'b0;
    if (io_ready) pulses++;
    bvalid = 1'b1;
    bdata  = 32'hBBBB_0002;
    tick();
    bvalid = 1'b0;
    if (io_ready) pulses++;
    checkOutput("b2b_data2", io_read_data, 32'hBBBB_0002);
    tick();
    if (io_ready) pulses++;
    checkOutput("b2b_pulses", pulses, 32'd2);

    // reset in WAIT, then a late bvalid
    applyStimulus(1'b0, 1'b1, 32'h0000_3000, 32'h5555_5555, 4'h3);
    tick();
    clearStrobe();
    aready = 1'b1;
    tick();
    aready = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("mrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mrst_awe", {31'd0, awe}, 32'd0);
    checkOutput("mrst_aaddr", {2'b00, aaddr}, 32'd0);
    checkOutput("mrst_astrb", {28'd0, astrb}, 32'd0);
    checkOutput("mrst_overrun", {31'd0, overrun}, 32'd0);
    tick();
    rst_n  = 1'b1;
    bvalid = 1'b1;
    bdata  = 32'h9999_9999;
    tick();
    bvalid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (io_ready) pulses++;
      tick();
    end
    checkOutput("mrst_pulses", pulses, 32'd0);
    checkOutput("mrst_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("mrst_rdata", io_read_data, 32'd0);

`ifdef IO_TO_AXI_TIMEOUT_EN
    // never accepted: abort after 8 cycles of avalid
    applyStimulus(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
    tick();
    clearStrobe();
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("to_avalid%0d", i), {31'd0, avalid}, 32'd1);
      tick();
    end
    checkOutput("to_avalid_drop", {31'd0, avalid}, 32'd0);
    checkOutput("to_ready", {31'd0, io_ready}, 32'd1);
    checkOutput("to_data", io_read_data, 32'hFFFF_FFFF);
    checkOutput("to_flag", {31'd0, timeout}, 32'd1);
    tick();
    checkOutput("to_ready_off", {31'd0, io_ready}, 32'd0);
    doReset();
    checkOutput("to_rst_flag", {31'd0, timeout}, 32'd0);

    // bvalid in the expiry cycle wins
    applyStimulus(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'h0);
    tick();
    clearStrobe();
    aready = 1'b1;
    tick();
    aready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    bvalid = 1'b1;
    bdata  = 32'h0BAD_F00D;
    tick();
    bvalid = 1'b0;
    checkOutput("tow_ready", {31'd0, io_ready}, 32'd1);
    checkOutput("tow_data", io_read_data, 32'h0BAD_F00D);
    checkOutput("tow_flag", {31'd0, timeout}, 32'd0);
    tick();
`else
    // without the timeout feature a stalled request just waits
    applyStimulus(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
    tick();
    clearStrobe();
    for (int i = 0; i < 20; i++) tick();
    checkOutput("nto_avalid", {31'd0, avalid}, 32'd1);
    checkOutput("nto_busy", {31'd0, busy}, 32'd1);
    checkOutput("nto_flag", {31'd0, timeout}, 32'd0);
    doReset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
